// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the parameterised serial sequence detector.
package seq_detect_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] DEFAULT_PAT = 4'b1101;

endpackage

// File: rtl/seq_shift_reg.sv
// Serial-in history register: shifts left on en, newest bit lands in q[0].
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[W-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern and overlap select.
// Optional saturating match counter enabled by defining SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEFAULT_PAT),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_valid,
  input  logic             x,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             z,
  output logic [PAT_W-1:0] seq,
  output logic [PAT_W-1:0] pat,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int              FW      = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]   FILL_M1 = FW'(PAT_W - 1);

  state_t           state_d, state_q;
  logic [FW-1:0]    fill_d, fill_q;
  logic [PAT_W-1:0] pat_d, pat_q;
  logic             z_d, z_q;
  logic [PAT_W-1:0] shifted;
  logic             full;
  logic             match;

  seq_shift_reg #(.W(PAT_W)) u_hist (
    .clk   (clk),
    .reset (reset),
    .en    (x_valid),
    .d     (x),
    .q     (seq)
  );

  assign shifted = {seq[PAT_W-2:0], x};

  // pat_load wins over matching: the bit is shifted into history but not counted.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    z_d     = 1'b0;
    full    = 1'b0;
    match   = 1'b0;
    if (pat_load) begin
      pat_d   = pat_in;
      fill_d  = '0;
      state_d = FILL;
    end else if (x_valid) begin
      full  = (state_q == RUN) || (fill_q == FILL_M1);
      match = full && (shifted == pat_q);
      if (state_q == FILL) begin
        fill_d = fill_q + 1'b1;
        if (full) state_d = RUN;
      end
      if (match) begin
        z_d = 1'b1;
        if (!overlap) begin
          state_d = FILL;
          fill_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      pat_q   <= PAT_RST;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      z_q     <= z_d;
    end
  end

  assign z   = z_q;
  assign pat = pat_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (pat_load)                     cnt_d = '0;
    else if (match && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic against a bit-history model.
module tb_seq_detect_param;
  import seq_detect_pkg::*;

  localparam int PAT_W = 4;
  localparam int MASK  = (1 << PAT_W) - 1;

  logic       clk = 1'b0;
  logic       reset, x_valid, x, pat_load, overlap;
  logic [3:0] pat_in;
  logic       z_a, z_b;
  logic [3:0] seq_a, seq_b, pat_a, pat_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  seq_detect_param u_dut (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .z(z_a), .seq(seq_a), .pat(pat_a), .match_cnt(cnt_a)
  );

  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .z(z_b), .seq(seq_b), .pat(pat_b), .match_cnt(cnt_b)
  );

  // Reference: bits accepted since the last restart, the last PAT_W of them, and matches seen.
  int m_hist, m_pat, m_since, m_matches, m_z;
  int n_pass = 0, n_total = 0;

  function automatic int cnt_exp(input int sat);
`ifdef SEQ_DETECT_MATCH_CNT_EN
    return (m_matches > sat) ? sat : m_matches;
`else
    return 0 + (sat & 0);
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic rst, input logic vld, input logic xb,
                      input logic ld, input logic [3:0] pin, input logic ovl);
    reset = rst; x_valid = vld; x = xb; pat_load = ld; pat_in = pin; overlap = ovl;
    if (rst) begin
      m_hist = 0; m_pat = int'(DEFAULT_PAT); m_since = 0; m_matches = 0; m_z = 0;
    end else begin
      m_z = 0;
      if (vld) m_hist = ((m_hist << 1) | int'(xb)) & MASK;
      if (ld) begin
        m_pat = int'(pin); m_since = 0; m_matches = 0;
      end else if (vld) begin
        if (m_since < PAT_W) m_since++;
        if (m_since >= PAT_W && m_hist == m_pat) begin
          m_z = 1;
          m_matches++;
          if (!ovl) m_since = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("z",      int'(z_a),   m_z);
    chk("seq",    int'(seq_a), m_hist);
    chk("pat",    int'(pat_a), m_pat);
    chk("cnt",    int'(cnt_a), cnt_exp(255));
    chk("z_c2",   int'(z_b),   m_z);
    chk("cnt_c2", int'(cnt_b), cnt_exp(3));
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input logic ovl);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, 4'h0, ovl);
  endtask

  initial begin
    logic [15:0] s;
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1);   // reset beats pat_load
    chk("rst_z", int'(z_a), 0);
    chk("rst_pat", int'(pat_a), 13);

    s = 16'b1101101; stream(s, 7, 1'b1);        // overlapping: two hits
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    stream(s, 7, 1'b0);                          // non-overlapping: one hit

    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1);   // all-zero pattern
    s = 16'b0; stream(s, 6, 1'b1);

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);   // gapped stream 1 1 0 ... 1
    s = 16'b1101;
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, s[i], 1'b0, 4'h0, 1'b1);
      if (i > 0) for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    end

    s = 16'b110; stream(s, 3, 1'b1);            // mid-stream reset drops history
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    s = 16'b1101; stream(s, 4, 1'b1);

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);   // five overlapping hits saturate 2-bit count
    s = 16'b1101101101101101; stream(s, 16, 1'b1);

    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b1);   // load with a valid bit: shifted, not counted

    for (int i = 0; i < 800; i++) begin
      logic r, v, xb, ld, ov;
      logic [3:0] p;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 9) < 7);
      xb = 1'($urandom);
      ld = ($urandom_range(0, 39) == 0);
      p  = 4'($urandom);
      ov = ($urandom_range(0, 3) != 0);
      step(r, v, xb, ld, p, ov);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
